axi_packet_gate: RTL and testbench

AXI_PACKET_GATE -- requirements
Module: axi_packet_gate

---
 rtl/axi_packet_gate.sv | 118 +++++++++++
 tb/tb_axi_packet_gate.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_packet_gate.sv
// Store-and-forward packet gate. Packets are released only once their last
// beat is accepted clean; a last beat flagged with an error rewinds and drops the packet.
module axi_packet_gate #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned SIZE  = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic [WIDTH-1:0] i_tdata,
   input  logic             i_tlast,
   input  logic             i_terror,
   input  logic             i_tvalid,
   output logic             i_tready,
   output logic [WIDTH-1:0] o_tdata,
   output logic             o_tlast,
   output logic             o_tvalid,
   input  logic             o_tready
);

   localparam int unsigned DEPTH = 2 ** SIZE;
   localparam logic [SIZE-1:0] PTR_ONE = {{(SIZE-1){1'b0}}, 1'b1};

   logic [WIDTH:0]    ram_q [DEPTH];
   logic [SIZE-1:0]   wr_ptr_q, wr_ptr_d;
   logic [SIZE-1:0]   rd_ptr_q, rd_ptr_d;
   logic [SIZE-1:0]   end_ptr_q, end_ptr_d;
   logic              ready_q;
   logic              o_valid_q, o_valid_d;
   logic [WIDTH-1:0]  o_data_q, o_data_d;
   logic              o_last_q, o_last_d;

   logic [SIZE-1:0]   wr_next;
   logic [SIZE-1:0]   head_ptr;
   logic [WIDTH:0]    rd_word;
   logic              full;
   logic              in_fire;
   logic              out_fire;
   logic              fetch;

   // The word held in the output register still occupies its slot until it
   // is handed off, so fullness is measured from one behind the fetch pointer.
   assign head_ptr = o_valid_q ? (rd_ptr_q - PTR_ONE) : rd_ptr_q;
   assign wr_next  = wr_ptr_q + PTR_ONE;
   assign full     = (wr_next == head_ptr);
   assign i_tready = ready_q & ~full;
   assign in_fire  = i_tvalid & i_tready;
   assign out_fire = o_valid_q & o_tready;
   assign rd_word  = ram_q[rd_ptr_q];
   assign fetch    = (rd_ptr_q != end_ptr_q) && (!o_valid_q || o_tready);

   assign o_tvalid = o_valid_q;
   assign o_tdata  = o_data_q;
   assign o_tlast  = o_last_q;

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      end_ptr_d = end_ptr_q;
      o_valid_d = o_valid_q;
      o_data_d  = o_data_q;
      o_last_d  = o_last_q;

      if (in_fire) begin
         if (i_tlast && i_terror) begin
            wr_ptr_d = end_ptr_q;
         end else begin
            wr_ptr_d = wr_next;
            if (i_tlast) begin
               end_ptr_d = wr_next;
            end
         end
      end

      if (fetch) begin
         rd_ptr_d  = rd_ptr_q + PTR_ONE;
         o_valid_d = 1'b1;
         o_data_d  = rd_word[WIDTH-1:0];
         o_last_d  = rd_word[WIDTH];
      end else if (out_fire) begin
         o_valid_d = 1'b0;
      end

      if (clear) begin
         wr_ptr_d  = '0;
         rd_ptr_d  = '0;
         end_ptr_d = '0;
         o_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         end_ptr_q <= '0;
         ready_q   <= 1'b0;
         o_valid_q <= 1'b0;
         o_data_q  <= '0;
         o_last_q  <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         end_ptr_q <= end_ptr_d;
         ready_q   <= 1'b1;
         o_valid_q <= o_valid_d;
         o_data_q  <= o_data_d;
         o_last_q  <= o_last_d;
      end
   end

   always_ff @(posedge clk) begin
      if (in_fire) begin
         ram_q[wr_ptr_q] <= {i_tlast, i_tdata};
      end
   end

endmodule

// File: tb/tb_axi_packet_gate.sv
// Scoreboard bench for axi_packet_gate: a default-size instance for ordering,
// drop, gating, clear and reset, and a SIZE=4 instance for the full boundary.
module tb_axi_packet_gate;

   logic        clk = 1'b0;
   logic        reset;
   logic        clear;
   logic [63:0] i_tdata;
   logic        i_tlast, i_terror, i_tvalid, i_tready;
   logic [63:0] o_tdata;
   logic        o_tlast, o_tvalid, o_tready;

   logic [7:0]  s_i_tdata;
   logic        s_i_tlast, s_i_tvalid, s_i_tready;
   logic [7:0]  s_o_tdata;
   logic        s_o_tlast, s_o_tvalid, s_o_tready;

   int          checks = 0;
   int          errors = 0;
   logic [64:0] exp_q[$];
   logic [64:0] pend[$];
   logic        hold_pending = 1'b0;
   logic [64:0] held;

   always #5 clk = ~clk;

   axi_packet_gate #(.WIDTH(64), .SIZE(10)) dut (
      .clk(clk), .reset(reset), .clear(clear),
      .i_tdata(i_tdata), .i_tlast(i_tlast), .i_terror(i_terror),
      .i_tvalid(i_tvalid), .i_tready(i_tready),
      .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready)
   );

   axi_packet_gate #(.WIDTH(8), .SIZE(4)) dut4 (
      .clk(clk), .reset(reset), .clear(clear),
      .i_tdata(s_i_tdata), .i_tlast(s_i_tlast), .i_terror(1'b0),
      .i_tvalid(s_i_tvalid), .i_tready(s_i_tready),
      .o_tdata(s_o_tdata), .o_tlast(s_o_tlast), .o_tvalid(s_o_tvalid), .o_tready(s_o_tready)
   );

   // One clock cycle: monitor the main output mid-cycle, then return just after the edge.
   task automatic tick();
      logic [64:0] e;
      @(negedge clk);
      if (hold_pending) begin
         checks++;
         if (o_tvalid !== 1'b1 || {o_tlast, o_tdata} !== held) begin
            errors++;
            $display("FAIL hold_stable: got valid=%b word=%h, required valid=1 word=%h",
                     o_tvalid, {o_tlast, o_tdata}, held);
         end
      end
      hold_pending = o_tvalid && !o_tready && !clear && reset;
      held = {o_tlast, o_tdata};
      if (o_tvalid === 1'b1 && o_tready === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL out_unexpected: got word=%h, required no output", {o_tlast, o_tdata});
         end else begin
            e = exp_q.pop_front();
            if ({o_tlast, o_tdata} !== e) begin
               errors++;
               $display("FAIL out_word: got %h, required %h", {o_tlast, o_tdata}, e);
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send_beat(input logic [63:0] d, input logic last, input logic err);
      bit ok = 1'b0;
      i_tdata  = d;
      i_tlast  = last;
      i_terror = err;
      i_tvalid = 1'b1;
      for (int n = 0; n < 100 && !ok; n++) begin
         ok = (i_tready === 1'b1);
         tick();
      end
      i_tvalid = 1'b0;
      i_tlast  = 1'b0;
      i_terror = 1'b0;
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: data %h i_tready=%b, required 1", d, i_tready);
      end else begin
         pend.push_back({last, d});
         if (last) begin
            if (!err) begin
               while (pend.size() > 0) exp_q.push_back(pend.pop_front());
            end else begin
               pend.delete();
            end
         end
      end
   endtask

   task automatic send_packet(input logic [63:0] base, input int n, input logic err);
      for (int i = 0; i < n; i++) begin
         send_beat(base + 64'(i), (i == n - 1), err && (i == n - 1));
      end
   endtask

   task automatic drain();
      o_tready = 1'b1;
      for (int n = 0; n < 300 && exp_q.size() > 0; n++) tick();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: %0d words left, required 0", exp_q.size());
      end
      for (int n = 0; n < 4; n++) tick();
   endtask

   task automatic test_reset();
      reset = 1'b0; clear = 1'b0; o_tready = 1'b0;
      i_tdata = '0; i_tlast = 1'b0; i_terror = 1'b0; i_tvalid = 1'b0;
      s_i_tdata = '0; s_i_tlast = 1'b0; s_i_tvalid = 1'b0; s_o_tready = 1'b0;
      #2;
      checks++;
      if ({i_tready, o_tvalid, o_tlast, o_tdata} !== 67'd0) begin
         errors++;
         $display("FAIL reset_state: got rdy=%b vld=%b last=%b data=%h, required all 0",
                  i_tready, o_tvalid, o_tlast, o_tdata);
      end
      @(posedge clk);
      #1;
      reset = 1'b1;
      tick();
      checks++;
      if (i_tready !== 1'b1 || o_tvalid !== 1'b0 || s_i_tready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release: got rdy=%b vld=%b small_rdy=%b, required 1 0 1",
                  i_tready, o_tvalid, s_i_tready);
      end
   endtask

   task automatic test_ordering();
      o_tready = 1'b0;
      send_packet(64'hA0, 16, 1'b0);
      send_packet(64'hB0, 16, 1'b0);
      tick();
      checks++;
      if (o_tvalid !== 1'b1 || o_tdata !== 64'hA0 || o_tlast !== 1'b0) begin
         errors++;
         $display("FAIL order_head: got vld=%b last=%b data=%h, required 1 0 a0",
                  o_tvalid, o_tlast, o_tdata);
      end
      drain();
   endtask

   task automatic test_drop();
      o_tready = 1'b1;
      send_packet(64'hC0, 16, 1'b1);
      send_packet(64'hD0, 16, 1'b0);
      send_packet(64'hE0, 16, 1'b0);
      send_packet(64'hF0, 16, 1'b0);
      drain();
   endtask

   task automatic test_gate();
      int lat = 0;
      o_tready = 1'b1;
      for (int i = 0; i < 14; i++) begin
         send_beat(64'h100 + 64'(i), 1'b0, (i % 3) == 1);
         checks++;
         if (o_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL gate_closed: beat %0d got o_tvalid=%b, required 0", i, o_tvalid);
         end
      end
      send_beat(64'h10E, 1'b1, 1'b0);
      while (o_tvalid !== 1'b1 && lat < 3) begin
         tick();
         lat++;
      end
      checks++;
      if (o_tvalid !== 1'b1) begin
         errors++;
         $display("FAIL gate_latency: got o_tvalid=%b after %0d cycles, required 1", o_tvalid, lat);
      end
      drain();
   endtask

   task automatic test_full();
      s_o_tready = 1'b0;
      for (int i = 0; i < 15; i++) begin
         s_i_tdata  = i[7:0];
         s_i_tlast  = (i == 14);
         s_i_tvalid = 1'b1;
         checks++;
         if (s_i_tready !== 1'b1) begin
            errors++;
            $display("FAIL full_accept: word %0d got i_tready=%b, required 1", i, s_i_tready);
         end
         tick();
      end
      s_i_tvalid = 1'b0;
      s_i_tlast  = 1'b0;
      checks++;
      if (s_i_tready !== 1'b0) begin
         errors++;
         $display("FAIL full_drop: got i_tready=%b, required 0", s_i_tready);
      end
      tick();
      checks++;
      if (s_i_tready !== 1'b0 || s_o_tvalid !== 1'b1 || s_o_tdata !== 8'h00) begin
         errors++;
         $display("FAIL full_hold: got rdy=%b vld=%b data=%h, required 0 1 00",
                  s_i_tready, s_o_tvalid, s_o_tdata);
      end
      s_o_tready = 1'b1;
      tick();
      s_o_tready = 1'b0;
      checks++;
      if (s_i_tready !== 1'b1 || s_o_tdata !== 8'h01) begin
         errors++;
         $display("FAIL full_restore: got rdy=%b data=%h, required 1 01", s_i_tready, s_o_tdata);
      end
   endtask

   task automatic test_clear();
      o_tready = 1'b0;
      send_packet(64'h10, 4, 1'b0);
      send_beat(64'h20, 1'b0, 1'b0);
      send_beat(64'h21, 1'b0, 1'b0);
      send_beat(64'h22, 1'b0, 1'b0);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      exp_q.delete();
      pend.delete();
      checks++;
      if (o_tvalid !== 1'b0 || i_tready !== 1'b1) begin
         errors++;
         $display("FAIL clear_flush: got vld=%b rdy=%b, required 0 1", o_tvalid, i_tready);
      end
      send_packet(64'h30, 5, 1'b0);
      drain();
   endtask

   task automatic test_reset_mid();
      o_tready = 1'b0;
      send_packet(64'h50, 6, 1'b0);
      send_beat(64'h40, 1'b0, 1'b0);
      send_beat(64'h41, 1'b0, 1'b0);
      tick();
      checks++;
      if (o_tvalid !== 1'b1 || o_tdata !== 64'h50) begin
         errors++;
         $display("FAIL pre_reset: got vld=%b data=%h, required 1 50", o_tvalid, o_tdata);
      end
      i_tdata  = 64'h42;
      i_tvalid = 1'b1;
      #1;
      reset = 1'b0;
      #1;
      hold_pending = 1'b0;
      checks++;
      if ({i_tready, o_tvalid, o_tlast, o_tdata} !== 67'd0) begin
         errors++;
         $display("FAIL reset_mid: got rdy=%b vld=%b last=%b data=%h, required all 0",
                  i_tready, o_tvalid, o_tlast, o_tdata);
      end
      i_tvalid = 1'b0;
      exp_q.delete();
      pend.delete();
      tick();
      tick();
      reset = 1'b1;
      tick();
      checks++;
      if (i_tready !== 1'b1 || o_tvalid !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_release: got rdy=%b vld=%b, required 1 0", i_tready, o_tvalid);
      end
      send_packet(64'h60, 8, 1'b0);
      send_packet(64'h70, 3, 1'b1);
      send_packet(64'h80, 5, 1'b0);
      drain();
   endtask

   initial begin
      test_reset();
      test_full();
      test_ordering();
      test_drop();
      test_gate();
      test_clear();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
